id_ctrl_pipe: RTL and testbench
===============================

# id_ctrl_pipe

Registered instruction-decode stage for the five-stage MIPS pipeline. It decodes the IF/ID instruction into the full control bundle and launches that bundle into the ID/EX register. It also owns the pipeline's stall generation: load-use interlock and a parametrised multi-cycle mult/div hold. Branch/jump flushes from later stages turn the launched slot into a bubble.

## Interface
- ALUOP_W, 3: ALU operation code width; must be ≥3.
- MULDIV_LAT, 4: EX occupancy of mult/div in cycles; range 1..15.
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- instr_i  in  32  IF/ID instruction
- valid_i  in  1  IF/ID slot holds a real instruction
- flush_i  in  1  taken branch/jump resolved downstream; kill ID slot
- stall_o  out  1  hold PC and IF/ID this cycle
- ex_valid_o  out  1  ID/EX slot valid
- alu_op_o  out  ALUOP_W  000 ADD, 001 SUB, 010 R-funct, 011 SLT, 100 MULDIV
- alu_src_o, branch_o, mem_read_o, mem_write_o, reg_write_o  out  1 each
- branch_type_o  out  2  00 beq, 11 bne, 01 bgtz, 10 bgez
- jump_o  out  2  00 j/jal, 01 sequential, 10 jr
- mem_to_reg_o  out  2  00 ALU, 01 memory, 11 PC+4
- reg_dst_o  out  2  00 rt, 01 rd, 10 $31
- ex_rt_o  out  5  registered rt of ID/EX instruction
- md_busy_o  out  1  mult/div occupying EX

## Operation
- Decode is combinational on instr_i[31:26] (op) and [5:0] (funct); the result is registered into ID/EX.
  - Branch: op 000100/000101/000001/000111.
  - ALUSrc: op 0010xx, lw (100011), sw (101011).
  - RegWrite: R-type (except jr and mult/div), 0010xx, lw, jal.
  - MemRead: lw only. MemWrite: sw only.
  - ALUOp:
    - ADD for j/jal/addi/addiu/lw/sw.
    - SUB for beq.
    - SLT for slti.
    - MULDIV for R-type funct 011000/011010.
    - R-funct otherwise.
- Register use:
  - rs is used by everything except j/jal.
  - rt is used by R-type, beq, bne, sw.
- Load-use hazard when all of the following hold:
  - ex_valid_o and mem_read_o are set;
  - valid_i is set;
  - ex_rt_o ≠ 0;
  - ex_rt_o equals a used rs or rt of instr_i.
  - Response: stall_o=1 and a bubble is launched.
- Bubble: ex_valid_o=0, jump_o=01, every other control output 0.
- FSM states RUN and MD_BUSY:
  - RUN → MD_BUSY when a valid mult/div launches and MULDIV_LAT>1; the counter loads MULDIV_LAT−1.
  - In MD_BUSY: stall_o=1, bubbles launch, counter decrements; at counter 1 → RUN.
  - With MULDIV_LAT=1, mult/div never stalls.
- Priority: flush_i > MD_BUSY stall > load-use stall > normal launch.
  - flush_i launches a bubble, forces RUN, clears the counter, and drives stall_o=0 that cycle.
- Invalid (valid_i=0) slots launch bubbles and never raise a load-use stall.

## Timing
- Reset (rst_i low, takes effect immediately):
  - All outputs 0, except jump_o=01.
  - State RUN, counter 0.
- Launch latency is 1 cycle: a control word appears on outputs the edge after instr_i is accepted.
- stall_o is combinational from registered state plus instr_i, and is valid in the same cycle.
- Load-use costs exactly 1 stall cycle. The next cycle sees the bubble in ID/EX, so the hazard clears.
- Mult/div costs MULDIV_LAT−1 stall cycles after its launch edge.
- Load-use and MD_BUSY in the same cycle: one stall, and the counter still decrements.
- Reset asserted mid MD_BUSY aborts to RUN with no residual stall.

## Structure
- Package id_ctrl_pkg holds:
  - opcode and funct constants;
  - ALUOp, BranchType, Jump, MemToReg and RegDst encodings;
  - the state enum {RUN, MD_BUSY}.
- Sub-module ctrl_decode_core: purely combinational op/funct → control bundle plus rs/rt-used flags.
- The top level holds the hazard logic, FSM/counter and the ID/EX registers.

## Test plan
- Reset mid-stream, then release:
  - all outputs 0 except jump_o=01;
  - first valid addi launches alu_op_o=000, alu_src_o=1, reg_write_o=1, reg_dst_o=00 one cycle later.
- lw $8 followed by add $9,$8,$2:
  - stall_o=1 for exactly one cycle;
  - one bubble, then the add launches with alu_op_o=010, reg_dst_o=01.
- lw $0 followed by a consumer of $0: no stall.
- lw $8 followed by sw $8,0($3): stall. lw $8 followed by j: no stall.
- mult with MULDIV_LAT=4: md_busy_o high for 3 cycles and stall_o high 3 cycles. With MULDIV_LAT=1: zero stalls.
- flush_i during MD_BUSY and during a load-use stall:
  - bubble launched, state RUN, stall_o=0 that cycle;
  - the next instruction launches normally.

Source files
------------

// File: rtl/id_ctrl_pkg.sv
// Shared encodings, state enum and control bundle for the ID stage.
package id_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned ALU_ENC_W = 3;
  localparam int unsigned CNT_W    = 4;

  localparam logic [OP_W-1:0] OP_RTYPE  = 6'b000000;
  localparam logic [OP_W-1:0] OP_REGIMM = 6'b000001;
  localparam logic [OP_W-1:0] OP_J      = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL    = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE    = 6'b000101;
  localparam logic [OP_W-1:0] OP_BGTZ   = 6'b000111;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU  = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI   = 6'b001010;
  localparam logic [OP_W-1:0] OP_SLTIU  = 6'b001011;
  localparam logic [OP_W-1:0] OP_LW     = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  localparam logic [ALU_ENC_W-1:0] ALU_ADD    = 3'b000;
  localparam logic [ALU_ENC_W-1:0] ALU_SUB    = 3'b001;
  localparam logic [ALU_ENC_W-1:0] ALU_RFUNCT = 3'b010;
  localparam logic [ALU_ENC_W-1:0] ALU_SLT    = 3'b011;
  localparam logic [ALU_ENC_W-1:0] ALU_MULDIV = 3'b100;

  localparam logic [1:0] BT_BEQ  = 2'b00;
  localparam logic [1:0] BT_BGTZ = 2'b01;
  localparam logic [1:0] BT_BGEZ = 2'b10;
  localparam logic [1:0] BT_BNE  = 2'b11;

  localparam logic [1:0] JMP_J   = 2'b00;
  localparam logic [1:0] JMP_SEQ = 2'b01;
  localparam logic [1:0] JMP_JR  = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b11;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

  typedef enum logic {RUN, MD_BUSY} state_t;

  typedef struct packed {
    logic [ALU_ENC_W-1:0] alu_op;
    logic                 alu_src;
    logic                 branch;
    logic [1:0]           branch_type;
    logic [1:0]           jump;
    logic                 mem_read;
    logic                 mem_write;
    logic [1:0]           mem_to_reg;
    logic [1:0]           reg_dst;
    logic                 reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    alu_op: ALU_ADD, alu_src: 1'b0, branch: 1'b0, branch_type: BT_BEQ,
    jump: JMP_SEQ, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: MTR_ALU,
    reg_dst: RDST_RT, reg_write: 1'b0
  };

endpackage

// File: rtl/id_ctrl_pipe_decode.sv
// Combinational op/funct decoder producing the control bundle and register-use flags.
module ctrl_decode_core
  import id_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [5:0]      funct,
  output ctrl_t           ctrl_c,
  output logic            rs_used_c,
  output logic            rt_used_c,
  output logic            muldiv_c
);

  always_comb begin
    ctrl_c        = CTRL_BUBBLE;
    ctrl_c.alu_op = ALU_RFUNCT;
    rs_used_c     = 1'b1;
    rt_used_c     = 1'b0;
    muldiv_c      = 1'b0;
    case (op)
      OP_RTYPE: begin
        rt_used_c      = 1'b1;
        ctrl_c.reg_dst = RDST_RD;
        if (funct == FN_JR) begin
          ctrl_c.jump = JMP_JR;
        end else if (funct == FN_MULT || funct == FN_DIV) begin
          ctrl_c.alu_op = ALU_MULDIV;
          muldiv_c      = 1'b1;
        end else begin
          ctrl_c.reg_write = 1'b1;
        end
      end
      OP_J: begin
        ctrl_c.alu_op = ALU_ADD;
        ctrl_c.jump   = JMP_J;
        rs_used_c     = 1'b0;
      end
      OP_JAL: begin
        ctrl_c.alu_op     = ALU_ADD;
        ctrl_c.jump       = JMP_J;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = MTR_PC4;
        ctrl_c.reg_dst    = RDST_R31;
        rs_used_c         = 1'b0;
      end
      OP_BEQ: begin
        ctrl_c.alu_op      = ALU_SUB;
        ctrl_c.branch      = 1'b1;
        ctrl_c.branch_type = BT_BEQ;
        rt_used_c          = 1'b1;
      end
      OP_BNE: begin
        ctrl_c.branch      = 1'b1;
        ctrl_c.branch_type = BT_BNE;
        rt_used_c          = 1'b1;
      end
      OP_REGIMM: begin
        ctrl_c.branch      = 1'b1;
        ctrl_c.branch_type = BT_BGEZ;
      end
      OP_BGTZ: begin
        ctrl_c.branch      = 1'b1;
        ctrl_c.branch_type = BT_BGTZ;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.reg_write = 1'b1;
      end
      OP_SLTI: begin
        ctrl_c.alu_op    = ALU_SLT;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.reg_write = 1'b1;
      end
      OP_SLTIU: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_c.alu_op     = ALU_ADD;
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.mem_to_reg = MTR_MEM;
      end
      OP_SW: begin
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.mem_write = 1'b1;
        rt_used_c        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID stage: decode into the ID/EX register, load-use interlock and mult/div hold FSM.
module id_ctrl_pipe
  import id_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W    = 3,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        instr_i,
  input  logic               valid_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               alu_src_o,
  output logic               branch_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               reg_write_o,
  output logic [1:0]         branch_type_o,
  output logic [1:0]         jump_o,
  output logic [1:0]         mem_to_reg_o,
  output logic [1:0]         reg_dst_o,
  output logic [REG_W-1:0]   ex_rt_o,
  output logic               md_busy_o
);

  localparam bit MD_HOLDS = (MULDIV_LAT > 1);

  ctrl_t             dec_ctrl_c, ex_ctrl_q;
  logic              rs_used_c, rt_used_c, muldiv_c;
  logic              lu_hazard_c, launch_c;
  logic              ex_valid_q;
  logic [REG_W-1:0]  ex_rt_q, rs_c, rt_c;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              unused_instr_c;

  assign rs_c           = instr_i[25:21];
  assign rt_c           = instr_i[20:16];
  assign unused_instr_c = ^instr_i[15:6];

  ctrl_decode_core u_decode (
    .op        (instr_i[31:26]),
    .funct     (instr_i[5:0]),
    .ctrl_c    (dec_ctrl_c),
    .rs_used_c (rs_used_c),
    .rt_used_c (rt_used_c),
    .muldiv_c  (muldiv_c)
  );

  assign lu_hazard_c = ex_valid_q && ex_ctrl_q.mem_read && valid_i && (ex_rt_q != 5'd0) &&
                       ((rs_used_c && (rs_c == ex_rt_q)) || (rt_used_c && (rt_c == ex_rt_q)));

  // Hold FSM state and remaining mult/div occupancy
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, stall and launch decision; flush overrides every stall source
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_o  = 1'b0;
    launch_c = 1'b0;
    if (flush_i) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          stall_o  = lu_hazard_c;
          launch_c = valid_i && !lu_hazard_c;
          if (launch_c && muldiv_c && MD_HOLDS) begin
            state_d = MD_BUSY;
            cnt_d   = CNT_W'(MULDIV_LAT - 1);
          end
        end
        MD_BUSY: begin
          stall_o = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ID/EX register: decoded word on launch, bubble otherwise
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_ctrl_q  <= CTRL_BUBBLE;
      ex_valid_q <= 1'b0;
      ex_rt_q    <= '0;
    end else if (launch_c) begin
      ex_ctrl_q  <= dec_ctrl_c;
      ex_valid_q <= 1'b1;
      ex_rt_q    <= rt_c;
    end else begin
      ex_ctrl_q  <= CTRL_BUBBLE;
      ex_valid_q <= 1'b0;
      ex_rt_q    <= '0;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign alu_op_o      = ALUOP_W'(ex_ctrl_q.alu_op);
  assign alu_src_o     = ex_ctrl_q.alu_src;
  assign branch_o      = ex_ctrl_q.branch;
  assign branch_type_o = ex_ctrl_q.branch_type;
  assign jump_o        = ex_ctrl_q.jump;
  assign mem_read_o    = ex_ctrl_q.mem_read;
  assign mem_write_o   = ex_ctrl_q.mem_write;
  assign mem_to_reg_o  = ex_ctrl_q.mem_to_reg;
  assign reg_dst_o     = ex_ctrl_q.reg_dst;
  assign reg_write_o   = ex_ctrl_q.reg_write;
  assign ex_rt_o       = ex_rt_q;
  assign md_busy_o     = (state_q == MD_BUSY);

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe: decode, load-use, mult/div hold, flush and reset.
module tb_id_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;

  logic       stall0, exv0, src0, br0, mr0, mw0, rw0, mdb0;
  logic [2:0] alu0;
  logic [1:0] bt0, jmp0, mtr0, rdst0;
  logic [4:0] rt0;

  logic       stall1, exv1, src1, br1, mr1, mw1, rw1, mdb1;
  logic [2:0] alu1;
  logic [1:0] bt1, jmp1, mtr1, rdst1;
  logic [4:0] rt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ctrl_pipe #(.ALUOP_W(3), .MULDIV_LAT(4)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .instr_i(instr), .valid_i(valid), .flush_i(flush),
    .stall_o(stall0), .ex_valid_o(exv0), .alu_op_o(alu0), .alu_src_o(src0),
    .branch_o(br0), .mem_read_o(mr0), .mem_write_o(mw0), .reg_write_o(rw0),
    .branch_type_o(bt0), .jump_o(jmp0), .mem_to_reg_o(mtr0), .reg_dst_o(rdst0),
    .ex_rt_o(rt0), .md_busy_o(mdb0)
  );

  id_ctrl_pipe #(.ALUOP_W(3), .MULDIV_LAT(1)) u_dut_lat1 (
    .clk_i(clk), .rst_i(rst_n), .instr_i(instr), .valid_i(valid), .flush_i(flush),
    .stall_o(stall1), .ex_valid_o(exv1), .alu_op_o(alu1), .alu_src_o(src1),
    .branch_o(br1), .mem_read_o(mr1), .mem_write_o(mw1), .reg_write_o(rw1),
    .branch_type_o(bt1), .jump_o(jmp1), .mem_to_reg_o(mtr1), .reg_dst_o(rdst1),
    .ex_rt_o(rt1), .md_busy_o(mdb1)
  );

  // {alu_op, alu_src, branch, branch_type, jump, mem_read, mem_write, mem_to_reg, reg_dst, reg_write}
  function automatic logic [15:0] obs0();
    return {alu0, src0, br0, bt0, jmp0, mr0, mw0, mtr0, rdst0, rw0};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
    valid = v;
    instr = ins;
    flush = fl;
    #1;
  endtask

  localparam logic [15:0] W_BUBBLE = 16'b000_0_0_00_01_0_0_00_00_0;
  localparam logic [15:0] W_ADDI   = 16'b000_1_0_00_01_0_0_00_00_1;
  localparam logic [15:0] W_LW     = 16'b000_1_0_00_01_1_0_01_00_1;
  localparam logic [15:0] W_ADD    = 16'b010_0_0_00_01_0_0_00_01_1;
  localparam logic [15:0] W_SW     = 16'b000_1_0_00_01_0_1_00_00_0;
  localparam logic [15:0] W_J      = 16'b000_0_0_00_00_0_0_00_00_0;

  logic [31:0] i_lw8, i_add9, i_add10, i_mult;
  logic [31:0] tbl_instr [8];
  logic [15:0] tbl_exp   [8];
  int n_st, n_md, n_st1;

  initial begin
    i_lw8   = itype(6'b100011, 5'd1, 5'd8, 16'd0);
    i_add9  = rtype(5'd8, 5'd2, 5'd9, 6'b100000);
    i_add10 = rtype(5'd1, 5'd2, 5'd10, 6'b100000);
    i_mult  = rtype(5'd4, 5'd5, 5'd0, 6'b011000);

    tbl_instr[0] = itype(6'b000100, 5'd1, 5'd2, 16'd4);   tbl_exp[0] = 16'b001_0_1_00_01_0_0_00_00_0;
    tbl_instr[1] = itype(6'b000101, 5'd1, 5'd2, 16'd4);   tbl_exp[1] = 16'b010_0_1_11_01_0_0_00_00_0;
    tbl_instr[2] = itype(6'b000111, 5'd1, 5'd0, 16'd4);   tbl_exp[2] = 16'b010_0_1_01_01_0_0_00_00_0;
    tbl_instr[3] = itype(6'b000001, 5'd1, 5'd1, 16'd4);   tbl_exp[3] = 16'b010_0_1_10_01_0_0_00_00_0;
    tbl_instr[4] = {6'b000011, 26'd64};                    tbl_exp[4] = 16'b000_0_0_00_00_0_0_11_10_1;
    tbl_instr[5] = rtype(5'd31, 5'd0, 5'd0, 6'b001000);   tbl_exp[5] = 16'b010_0_0_00_10_0_0_00_01_0;
    tbl_instr[6] = itype(6'b001010, 5'd1, 5'd6, 16'd3);   tbl_exp[6] = 16'b011_1_0_00_01_0_0_00_00_1;
    tbl_instr[7] = itype(6'b100011, 5'd1, 5'd7, 16'd0);   tbl_exp[7] = W_LW;

    // Reset held, then a mult interrupted by reset while MD_BUSY
    repeat (3) @(posedge clk);
    #1;
    check("rst_word", 32'(obs0()), 32'(W_BUBBLE));
    check("rst_exv", 32'(exv0), 32'd0);
    check("rst_md_busy", 32'(mdb0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    drive(1'b1, i_mult, 1'b0);
    tick();
    check("pre_rst_md_busy", 32'(mdb0), 32'd1);
    drive(1'b1, i_add10, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_md_busy", 32'(mdb0), 32'd0);
    check("mid_rst_stall", 32'(stall0), 32'd0);
    check("mid_rst_word", 32'(obs0()), 32'(W_BUBBLE));
    check("mid_rst_exv", 32'(exv0), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // First instruction after reset
    drive(1'b1, itype(6'b001000, 5'd1, 5'd5, 16'd7), 1'b0);
    check("addi_stall", 32'(stall0), 32'd0);
    tick();
    check("addi_word", 32'(obs0()), 32'(W_ADDI));
    check("addi_exv", 32'(exv0), 32'd1);

    // lw $8 then add $9,$8,$2: one stall, one bubble
    drive(1'b1, i_lw8, 1'b0);
    tick();
    check("lw_word", 32'(obs0()), 32'(W_LW));
    check("lw_rt", 32'(rt0), 32'd8);
    drive(1'b1, i_add9, 1'b0);
    check("lu_stall", 32'(stall0), 32'd1);
    tick();
    check("lu_bubble_exv", 32'(exv0), 32'd0);
    check("lu_bubble_word", 32'(obs0()), 32'(W_BUBBLE));
    check("lu_stall_clear", 32'(stall0), 32'd0);
    tick();
    check("lu_add_word", 32'(obs0()), 32'(W_ADD));
    check("lu_add_exv", 32'(exv0), 32'd1);

    // lw $0 never interlocks
    drive(1'b1, itype(6'b100011, 5'd1, 5'd0, 16'd4), 1'b0);
    tick();
    drive(1'b1, rtype(5'd0, 5'd0, 5'd9, 6'b100000), 1'b0);
    check("lw0_stall", 32'(stall0), 32'd0);
    tick();
    check("lw0_exv", 32'(exv0), 32'd1);

    // lw $8 then sw $8 (rt use) stalls
    drive(1'b1, i_lw8, 1'b0);
    tick();
    drive(1'b1, itype(6'b101011, 5'd3, 5'd8, 16'd0), 1'b0);
    check("sw_stall", 32'(stall0), 32'd1);
    tick();
    check("sw_bubble_exv", 32'(exv0), 32'd0);
    check("sw_stall_clear", 32'(stall0), 32'd0);
    tick();
    check("sw_word", 32'(obs0()), 32'(W_SW));

    // lw $8 then j whose target bits alias rs/rt=8: no stall
    drive(1'b1, i_lw8, 1'b0);
    tick();
    drive(1'b1, {6'b000010, 5'd8, 5'd8, 16'd0}, 1'b0);
    check("j_stall", 32'(stall0), 32'd0);
    tick();
    check("j_word", 32'(obs0()), 32'(W_J));

    // lw $8 then addi writing $8 (rt not a source): no stall
    drive(1'b1, i_lw8, 1'b0);
    tick();
    drive(1'b1, itype(6'b001000, 5'd1, 5'd8, 16'd1), 1'b0);
    check("addi_rt_stall", 32'(stall0), 32'd0);
    tick();

    // Invalid slot after a load: no stall, bubble launched
    drive(1'b1, i_lw8, 1'b0);
    tick();
    drive(1'b0, i_add9, 1'b0);
    check("inv_stall", 32'(stall0), 32'd0);
    tick();
    check("inv_exv", 32'(exv0), 32'd0);

    // mult: LAT=4 holds 3 cycles, LAT=1 never holds
    drive(1'b1, i_mult, 1'b0);
    check("mult_stall", 32'(stall0), 32'd0);
    tick();
    check("mult_alu", 32'(alu0), 32'd4);
    check("mult_rw", 32'(rw0), 32'd0);
    check("mult_lat1_alu", 32'(alu1), 32'd4);
    drive(1'b1, i_add10, 1'b0);
    n_st = 0; n_md = 0; n_st1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (!stall0) break;
      n_st++;
      if (mdb0) n_md++;
      if (stall1 || mdb1) n_st1++;
      tick();
    end
    check("md_stall_cycles", 32'(n_st), 32'd3);
    check("md_busy_cycles", 32'(n_md), 32'd3);
    check("md_lat1_stalls", 32'(n_st1), 32'd0);
    check("md_busy_done", 32'(mdb0), 32'd0);
    tick();
    check("md_next_word", 32'(obs0()), 32'(W_ADD));
    check("md_next_exv", 32'(exv0), 32'd1);

    // flush during MD_BUSY
    drive(1'b1, i_mult, 1'b0);
    tick();
    drive(1'b1, i_add10, 1'b1);
    check("fl_md_stall", 32'(stall0), 32'd0);
    tick();
    check("fl_md_exv", 32'(exv0), 32'd0);
    check("fl_md_busy", 32'(mdb0), 32'd0);
    drive(1'b1, i_add10, 1'b0);
    check("fl_md_next_stall", 32'(stall0), 32'd0);
    tick();
    check("fl_md_next_word", 32'(obs0()), 32'(W_ADD));

    // flush during a load-use stall
    drive(1'b1, i_lw8, 1'b0);
    tick();
    drive(1'b1, i_add9, 1'b0);
    check("fl_lu_pre_stall", 32'(stall0), 32'd1);
    drive(1'b1, i_add9, 1'b1);
    check("fl_lu_stall", 32'(stall0), 32'd0);
    tick();
    check("fl_lu_exv", 32'(exv0), 32'd0);
    drive(1'b1, i_add9, 1'b0);
    check("fl_lu_next_stall", 32'(stall0), 32'd0);
    tick();
    check("fl_lu_next_word", 32'(obs0()), 32'(W_ADD));
    check("fl_lu_next_exv", 32'(exv0), 32'd1);

    // Decode table for branches, jumps and immediates
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, tbl_instr[k], 1'b0);
      tick();
      check($sformatf("dec_%0d", k), 32'(obs0()), 32'(tbl_exp[k]));
    end
    drive(1'b0, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
